// File: rtl/cpu_dma_arb_pkg.sv
// Shared types and helpers for the CPU DMA rx arbiter: state encoding,
// default widths and the round-robin successor function.
package cpu_dma_arb_pkg;

    localparam int DEF_NUM_QUEUES     = 4;
    localparam int DEF_DMA_DATA_WIDTH = 32;
    localparam int DEF_DMA_CTRL_WIDTH = DEF_DMA_DATA_WIDTH / 8;
    localparam int DEF_QSEL_WIDTH     = 2;
    localparam int DEF_WD_TIMEOUT     = 125000;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    // Queue index that follows idx, wrapping back to 0 after num_q-1.
    function automatic logic [7:0] rr_next(input logic [7:0] idx, input int unsigned num_q);
        logic [7:0] nxt;
        if ((32'(idx) + 32'd1) >= num_q) begin
            nxt = 8'd0;
        end else begin
            nxt = idx + 8'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/cpu_dma_rr_pick.sv
// Combinational round-robin picker: first requesting queue found when
// searching ptr, ptr+1, ... modulo NUM_QUEUES.
module cpu_dma_rr_pick
    import cpu_dma_arb_pkg::*;
#(
    parameter int NUM_QUEUES = DEF_NUM_QUEUES,
    parameter int QSEL_WIDTH = DEF_QSEL_WIDTH
) (
    input  logic [NUM_QUEUES-1:0] req,
    input  logic [QSEL_WIDTH-1:0] ptr,
    output logic                  valid,
    output logic [QSEL_WIDTH-1:0] idx
);

    int   dist_s;
    int   best_s;
    logic hit_s;

    // Pick the requester with the smallest circular distance from ptr.
    always_comb begin
        dist_s = 0;
        best_s = NUM_QUEUES;
        hit_s  = 1'b0;
        idx    = '0;
        valid  = |req;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            dist_s = (i >= int'(ptr)) ? (i - int'(ptr)) : (i + NUM_QUEUES - int'(ptr));
            hit_s  = req[i] && (dist_s < best_s);
            idx    = hit_s ? QSEL_WIDTH'(i) : idx;
            best_s = hit_s ? dist_s : best_s;
        end
    end

endmodule

// File: rtl/cpu_dma_rx_arbiter.sv
// Packet-granular round-robin arbiter sharing one DMA read engine among CPU queues.
// Optional stalled-grant watchdog enabled by defining CPU_DMA_RX_ARB_WATCHDOG_EN.
module cpu_dma_rx_arbiter
    import cpu_dma_arb_pkg::*;
#(
    parameter int NUM_QUEUES       = DEF_NUM_QUEUES,
    parameter int DMA_DATA_WIDTH   = DEF_DMA_DATA_WIDTH,
    parameter int DMA_CTRL_WIDTH   = DMA_DATA_WIDTH / 8,
    parameter int QSEL_WIDTH       = DEF_QSEL_WIDTH,
    parameter int WATCHDOG_TIMEOUT = DEF_WD_TIMEOUT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_QUEUES-1:0]                cpu_q_dma_pkt_avail,
    output logic [NUM_QUEUES-1:0]                cpu_q_dma_rd,
    input  logic [NUM_QUEUES*DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data,
    input  logic [NUM_QUEUES*DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl,
    output logic                                 dma_pkt_avail,
    output logic [QSEL_WIDTH-1:0]                dma_q_sel,
    input  logic                                 dma_rd,
    output logic [DMA_DATA_WIDTH-1:0]            dma_rd_data,
    output logic [DMA_CTRL_WIDTH-1:0]            dma_rd_ctrl,
    output logic                                 rd_err
`ifdef CPU_DMA_RX_ARB_WATCHDOG_EN
    ,
    output logic                                 arb_timeout
`endif
);

    arb_state_e              state_r;
    arb_state_e              state_s;
    logic [QSEL_WIDTH-1:0]   rr_ptr_r;
    logic [QSEL_WIDTH-1:0]   rr_ptr_s;
    logic [QSEL_WIDTH-1:0]   q_sel_r;
    logic [QSEL_WIDTH-1:0]   q_sel_s;
    logic                    rd_err_r;
    logic                    pick_valid_s;
    logic [QSEL_WIDTH-1:0]   pick_idx_s;
    logic [NUM_QUEUES-1:0]   grant_vec_s;
    logic [DMA_DATA_WIDTH-1:0] sel_data_s;
    logic [DMA_CTRL_WIDTH-1:0] sel_ctrl_s;
    logic                    eop_s;
    logic                    wd_fire_s;

    cpu_dma_rr_pick #(
        .NUM_QUEUES (NUM_QUEUES),
        .QSEL_WIDTH (QSEL_WIDTH)
    ) u_pick (
        .req   (cpu_q_dma_pkt_avail),
        .ptr   (rr_ptr_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    // One-hot grant vector and AND-OR mux of the granted queue's FWFT word.
    always_comb begin
        grant_vec_s = '0;
        sel_data_s  = '0;
        sel_ctrl_s  = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            grant_vec_s[i] = (state_r == ARB_GRANT) && (q_sel_r == QSEL_WIDTH'(i));
            sel_data_s = sel_data_s |
                ({DMA_DATA_WIDTH{grant_vec_s[i]}} & cpu_q_dma_rd_data[i*DMA_DATA_WIDTH +: DMA_DATA_WIDTH]);
            sel_ctrl_s = sel_ctrl_s |
                ({DMA_CTRL_WIDTH{grant_vec_s[i]}} & cpu_q_dma_rd_ctrl[i*DMA_CTRL_WIDTH +: DMA_CTRL_WIDTH]);
        end
    end

    assign eop_s = (state_r == ARB_GRANT) && dma_rd && (sel_ctrl_s != '0);

`ifdef CPU_DMA_RX_ARB_WATCHDOG_EN
    logic [16:0] wd_cnt_r;
    logic        arb_timeout_r;

    // Fires on the grant cycle that would bring the idle count up to the timeout.
    assign wd_fire_s = (state_r == ARB_GRANT) && !dma_rd &&
                       (wd_cnt_r == 17'(WATCHDOG_TIMEOUT - 1));

    // Idle-read counter for the held grant and the one-cycle timeout pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_r      <= 17'd0;
            arb_timeout_r <= 1'b0;
        end else begin
            arb_timeout_r <= wd_fire_s;
            if ((state_r != ARB_GRANT) || dma_rd || wd_fire_s) begin
                wd_cnt_r <= 17'd0;
            end else begin
                wd_cnt_r <= wd_cnt_r + 17'd1;
            end
        end
    end

    assign arb_timeout = arb_timeout_r;
`else
    assign wd_fire_s = 1'b0;
`endif

    // Next-state logic: grant the picked queue from IDLE, release on EOP or watchdog.
    always_comb begin
        state_s  = state_r;
        rr_ptr_s = rr_ptr_r;
        q_sel_s  = q_sel_r;
        case (state_r)
            ARB_IDLE: begin
                if (pick_valid_s) begin
                    state_s = ARB_GRANT;
                    q_sel_s = pick_idx_s;
                end else begin
                    state_s = ARB_IDLE;
                end
            end
            ARB_GRANT: begin
                if (eop_s || wd_fire_s) begin
                    state_s  = ARB_IDLE;
                    rr_ptr_s = QSEL_WIDTH'(rr_next(8'(q_sel_r), NUM_QUEUES));
                end else begin
                    state_s = ARB_GRANT;
                end
            end
            default: begin
                state_s = ARB_IDLE;
            end
        endcase
    end

    // State, round-robin pointer, granted id and sticky stray-read flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= ARB_IDLE;
            rr_ptr_r <= '0;
            q_sel_r  <= '0;
            rd_err_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            rr_ptr_r <= rr_ptr_s;
            q_sel_r  <= q_sel_s;
            if ((state_r == ARB_IDLE) && dma_rd) begin
                rd_err_r <= 1'b1;
            end
        end
    end

    assign dma_pkt_avail = (state_r == ARB_GRANT);
    assign dma_q_sel     = q_sel_r;
    assign cpu_q_dma_rd  = grant_vec_s & {NUM_QUEUES{dma_rd}};
    assign dma_rd_data   = sel_data_s;
    assign dma_rd_ctrl   = sel_ctrl_s;
    assign rd_err        = rd_err_r;

endmodule

// File: tb/tb_cpu_dma_rx_arbiter.sv
// Directed table-driven bench for cpu_dma_rx_arbiter, plus reset-mid-packet
// and watchdog (CPU_DMA_RX_ARB_WATCHDOG_EN) sequences.
module tb_cpu_dma_rx_arbiter;

    localparam logic [31:0] D0 = 32'hC0DE_0000;
    localparam logic [31:0] D1 = 32'hC0DE_0001;
    localparam logic [31:0] D2 = 32'hC0DE_0002;
    localparam logic [31:0] D3 = 32'hC0DE_0003;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   pkt_avail;
    logic [3:0]   q_rd;
    logic [127:0] q_data;
    logic [15:0]  q_ctrl;
    logic         dma_pkt_avail;
    logic [1:0]   dma_q_sel;
    logic         dma_rd;
    logic [31:0]  dma_rd_data;
    logic [3:0]   dma_rd_ctrl;
    logic         rd_err;
`ifdef CPU_DMA_RX_ARB_WATCHDOG_EN
    logic         arb_timeout;
`endif

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  avail;
        logic        rd;
        logic [3:0]  ctrl;
        logic        e_pa;
        logic [1:0]  e_sel;
        logic [3:0]  e_rd;
        logic [31:0] e_data;
        logic [3:0]  e_ctrl;
        logic        e_err;
    } vec_t;

    vec_t vq[$];

    cpu_dma_rx_arbiter #(
        .NUM_QUEUES       (4),
        .DMA_DATA_WIDTH   (32),
        .DMA_CTRL_WIDTH   (4),
        .QSEL_WIDTH       (2),
        .WATCHDOG_TIMEOUT (16)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .cpu_q_dma_pkt_avail (pkt_avail),
        .cpu_q_dma_rd        (q_rd),
        .cpu_q_dma_rd_data   (q_data),
        .cpu_q_dma_rd_ctrl   (q_ctrl),
        .dma_pkt_avail       (dma_pkt_avail),
        .dma_q_sel           (dma_q_sel),
        .dma_rd              (dma_rd),
        .dma_rd_data         (dma_rd_data),
        .dma_rd_ctrl         (dma_rd_ctrl),
        .rd_err              (rd_err)
`ifdef CPU_DMA_RX_ARB_WATCHDOG_EN
        ,
        .arb_timeout         (arb_timeout)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] av, input logic rd, input logic [3:0] c,
                       input logic pa, input logic [1:0] sel, input logic [3:0] erd,
                       input logic [31:0] ed, input logic [3:0] ec, input logic ee);
        vec_t v;
        v = '{av, rd, c, pa, sel, erd, ed, ec, ee};
        vq.push_back(v);
    endtask

    task automatic chk_outs(input string tag, input logic pa, input logic [1:0] sel,
                            input logic [3:0] erd, input logic [31:0] ed,
                            input logic [3:0] ec, input logic ee);
        chk({tag, "_pa"},   64'(dma_pkt_avail), 64'(pa));
        chk({tag, "_sel"},  64'(dma_q_sel),     64'(sel));
        chk({tag, "_qrd"},  64'(q_rd),          64'(erd));
        chk({tag, "_data"}, 64'(dma_rd_data),   64'(ed));
        chk({tag, "_ctrl"}, 64'(dma_rd_ctrl),   64'(ec));
        chk({tag, "_err"},  64'(rd_err),        64'(ee));
    endtask

    initial begin
        int  n;
        bit  seen;
        reset     = 1'b0;
        pkt_avail = 4'b0000;
        dma_rd    = 1'b0;
        q_ctrl    = 16'h0000;
        for (int i = 0; i < 4; i++) q_data[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);

        // single request to queue 2, 3-word packet
        add(4'b0100, 1'b0, 4'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b0100, 1'b1, 4'h0, 1'b1, 2'd2, 4'b0100, D2,    4'h0, 1'b0);
        add(4'b0100, 1'b1, 4'h0, 1'b1, 2'd2, 4'b0100, D2,    4'h0, 1'b0);
        add(4'b0100, 1'b1, 4'hF, 1'b1, 2'd2, 4'b0100, D2,    4'hF, 1'b0);
        // wrap: rr_ptr=3 with queues 3 and 0 requesting, single-word packets
        add(4'b1001, 1'b0, 4'h0, 1'b0, 2'd2, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b1001, 1'b1, 4'hF, 1'b1, 2'd3, 4'b1000, D3,    4'hF, 1'b0);
        add(4'b1001, 1'b0, 4'h0, 1'b0, 2'd3, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b1001, 1'b1, 4'hF, 1'b1, 2'd0, 4'b0001, D0,    4'hF, 1'b0);
        add(4'b0000, 1'b0, 4'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 4'h0, 1'b0);
        // fairness: all request, 2-word packets, order 1,2,3,0
        add(4'b1111, 1'b0, 4'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'h0, 1'b1, 2'd1, 4'b0010, D1,    4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'hF, 1'b1, 2'd1, 4'b0010, D1,    4'hF, 1'b0);
        add(4'b1111, 1'b0, 4'h0, 1'b0, 2'd1, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'h0, 1'b1, 2'd2, 4'b0100, D2,    4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'hF, 1'b1, 2'd2, 4'b0100, D2,    4'hF, 1'b0);
        add(4'b1111, 1'b0, 4'h0, 1'b0, 2'd2, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'h0, 1'b1, 2'd3, 4'b1000, D3,    4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'hF, 1'b1, 2'd3, 4'b1000, D3,    4'hF, 1'b0);
        add(4'b1111, 1'b0, 4'h0, 1'b0, 2'd3, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'h0, 1'b1, 2'd0, 4'b0001, D0,    4'h0, 1'b0);
        add(4'b1111, 1'b1, 4'hF, 1'b1, 2'd0, 4'b0001, D0,    4'hF, 1'b0);
        // avail drop mid-packet on queue 1
        add(4'b0010, 1'b0, 4'h0, 1'b0, 2'd0, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b0000, 1'b1, 4'h0, 1'b1, 2'd1, 4'b0010, D1,    4'h0, 1'b0);
        add(4'b0000, 1'b0, 4'h0, 1'b1, 2'd1, 4'b0000, D1,    4'h0, 1'b0);
        add(4'b0000, 1'b1, 4'hF, 1'b1, 2'd1, 4'b0010, D1,    4'hF, 1'b0);
        add(4'b0000, 1'b0, 4'h0, 1'b0, 2'd1, 4'b0000, 32'h0, 4'h0, 1'b0);
        // stray read in IDLE, rd_err sticky across a later packet
        add(4'b0000, 1'b1, 4'h0, 1'b0, 2'd1, 4'b0000, 32'h0, 4'h0, 1'b0);
        add(4'b0000, 1'b0, 4'h0, 1'b0, 2'd1, 4'b0000, 32'h0, 4'h0, 1'b1);
        add(4'b0100, 1'b0, 4'h0, 1'b0, 2'd1, 4'b0000, 32'h0, 4'h0, 1'b1);
        add(4'b0100, 1'b1, 4'hF, 1'b1, 2'd2, 4'b0100, D2,    4'hF, 1'b1);
        add(4'b0000, 1'b0, 4'h0, 1'b0, 2'd2, 4'b0000, 32'h0, 4'h0, 1'b1);

        repeat (2) @(negedge clk);
        #1;
        chk_outs("reset", 1'b0, 2'd0, 4'b0000, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;

        foreach (vq[k]) begin
            @(negedge clk);
            pkt_avail = vq[k].avail;
            dma_rd    = vq[k].rd;
            q_ctrl    = {4{vq[k].ctrl}};
            #1;
            chk_outs($sformatf("v%0d", k), vq[k].e_pa, vq[k].e_sel, vq[k].e_rd,
                     vq[k].e_data, vq[k].e_ctrl, vq[k].e_err);
        end

        // reset mid-packet: grant queue 0 (rr_ptr=3), then pull reset
        @(negedge clk);
        pkt_avail = 4'b0001;
        dma_rd    = 1'b0;
        q_ctrl    = 16'h0000;
        @(negedge clk);
        #1;
        chk("rst_pre_pa",  64'(dma_pkt_avail), 64'd1);
        chk("rst_pre_sel", 64'(dma_q_sel),     64'd0);
        dma_rd = 1'b1;
        reset  = 1'b0;
        #1;
        chk_outs("rst_mid", 1'b0, 2'd0, 4'b0000, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        reset     = 1'b1;
        dma_rd    = 1'b0;
        pkt_avail = 4'b1111;
        @(negedge clk);
        #1;
        chk("rst_ptr_pa",  64'(dma_pkt_avail), 64'd1);
        chk("rst_ptr_sel", 64'(dma_q_sel),     64'd0);

`ifdef CPU_DMA_RX_ARB_WATCHDOG_EN
        chk("wd_idle_pulse", 64'(arb_timeout), 64'd0);
        n    = 1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (arb_timeout) seen = 1'b1;
            else if (dma_pkt_avail) n++;
        end
        chk("wd_seen",   64'(seen),          64'd1);
        chk("wd_cycles", 64'(n),             64'd16);
        chk("wd_to_pa",  64'(dma_pkt_avail), 64'd0);
        @(negedge clk);
        #1;
        chk("wd_pulse_end", 64'(arb_timeout),   64'd0);
        chk("wd_next_pa",   64'(dma_pkt_avail), 64'd1);
        chk("wd_next_sel",  64'(dma_q_sel),     64'd1);
`else
        repeat (20) @(negedge clk);
        #1;
        chk("hold_pa",  64'(dma_pkt_avail), 64'd1);
        chk("hold_sel", 64'(dma_q_sel),     64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
